// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin arbiter sharing one stream sink between NB_IN requesters, with bursts of up to MAX_BURST beats per grant
module stream_rr_arbiter #(
    parameter int NB_IN      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    localparam int SW        = (DATA_WIDTH + 7) / 8
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                clear_i,
    input  logic [NB_IN-1:0]                    in_valid_i,
    output logic [NB_IN-1:0]                    in_ready_o,
    input  logic [NB_IN-1:0][DATA_WIDTH-1:0]    in_data_i,
    input  logic [NB_IN-1:0][SW-1:0]            in_strb_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [DATA_WIDTH-1:0]               out_data_o,
    output logic [SW-1:0]                       out_strb_o,
    output logic [NB_IN-1:0]                    grant_o,
    output logic                                busy_o
);
    localparam int PW = $clog2(NB_IN);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, LOCK} state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  rr_ptr_q, rr_ptr_d, grant_q, grant_d, w_idle, w;
    logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
    logic           found, sel_valid, hs;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(NB_IN - 1)) ? '0 : p + 1'b1;
    endfunction

    // first valid requester at or after rr_ptr_q, wrapping around
    always_comb begin
        int unsigned j;
        j      = 0;
        w_idle = '0;
        found  = 1'b0;
        for (int i = 0; i < NB_IN; i++) begin
            j = int'(rr_ptr_q) + i;
            if (j >= NB_IN) j -= NB_IN;
            if (!found && in_valid_i[j]) begin
                w_idle = PW'(j);
                found  = 1'b1;
            end
        end
    end

    assign w         = (state_q == LOCK) ? grant_q : w_idle;
    assign sel_valid = in_valid_i[w];
    assign hs        = sel_valid & out_ready_i;
    assign busy_o    = (state_q == LOCK);

    // zero-latency mux from the selected requester to the sink; everything idles at 0 without a valid source
    always_comb begin
        out_valid_o   = sel_valid;
        out_data_o    = sel_valid ? in_data_i[w] : '0;
        out_strb_o    = sel_valid ? in_strb_i[w] : '0;
        in_ready_o    = '0;
        in_ready_o[w] = hs;
        grant_o       = '0;
        grant_o[w]    = sel_valid;
    end

    // lock onto a valid source even without a handshake so it is never abandoned mid-beat
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        if (state_q == IDLE) begin
            if (sel_valid) begin
                if (MAX_BURST == 1 && hs) begin
                    rr_ptr_d = wrap_inc(w);
                end else begin
                    state_d    = LOCK;
                    grant_d    = w;
                    beat_cnt_d = CW'(hs);
                end
            end
        end else if (!sel_valid || (hs && beat_cnt_q == CW'(MAX_BURST - 1))) begin
            state_d    = IDLE;
            rr_ptr_d   = wrap_inc(grant_q);
            beat_cnt_d = '0;
        end else if (hs) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
    end

    // state registers with async reset and sync clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
        end else if (clear_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: directed tests of the round-robin stream arbiter (burst 4 and burst 1 instances)
module tb_stream_rr_arbiter;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0][31:0] data;
    logic [3:0][3:0]  strb;
    logic             a_clear = 1'b0, a_out_ready = 1'b0, a_out_valid, a_busy;
    logic [3:0]       a_valid = '0, a_ready, a_grant;
    logic [31:0]      a_data;
    logic [3:0]       a_strb;
    logic             b_clear = 1'b0, b_out_ready = 1'b0, b_out_valid, b_busy;
    logic [3:0]       b_valid = '0, b_ready, b_grant;
    logic [31:0]      b_data;
    logic [3:0]       b_strb;
    int               errors = 0, checks = 0;

    always #5 clk = ~clk;

    stream_rr_arbiter #(.NB_IN(4), .DATA_WIDTH(32), .MAX_BURST(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(a_clear),
        .in_valid_i(a_valid), .in_ready_o(a_ready), .in_data_i(data), .in_strb_i(strb),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_data), .out_strb_o(a_strb),
        .grant_o(a_grant), .busy_o(a_busy)
    );

    stream_rr_arbiter #(.NB_IN(4), .DATA_WIDTH(32), .MAX_BURST(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(b_clear),
        .in_valid_i(b_valid), .in_ready_o(b_ready), .in_data_i(data), .in_strb_i(strb),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_data), .out_strb_o(b_strb),
        .grant_o(b_grant), .busy_o(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_valid = '0; b_valid = '0; a_clear = 1'b0; b_clear = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_valid = '0; b_valid = '0; a_out_ready = 1'b1; b_out_ready = 1'b1;
        #2;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", a_out_valid); end
        checks++; if (a_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", a_data); end
        checks++; if (a_strb !== 4'h0) begin errors++; $display("FAIL reset_out_strb got %h exp 0", a_strb); end
        checks++; if (a_grant !== 4'h0) begin errors++; $display("FAIL reset_grant got %b exp 0000", a_grant); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", a_busy); end
        checks++; if (a_ready !== 4'h0) begin errors++; $display("FAIL reset_in_ready got %b exp 0000", a_ready); end
        checks++; if (b_grant !== 4'h0 || b_ready !== 4'h0) begin errors++; $display("FAIL reset_b_idle got grant %b ready %b exp 0000 0000", b_grant, b_ready); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (a_out_valid !== 1'b0 || a_ready !== 4'h0) begin errors++; $display("FAIL idle_after_reset got valid %b ready %b exp 0 0000", a_out_valid, a_ready); end
    endtask

    task automatic test_round_robin();
        int owner;
        do_reset();
        a_valid = 4'hF; a_out_ready = 1'b1;
        for (int n = 0; n < 18; n++) begin
            owner = (n / 4) % 4;
            #1;
            checks++; if (a_grant !== 4'(1 << owner)) begin errors++; $display("FAIL rr_grant beat %0d got %b exp %b", n, a_grant, 4'(1 << owner)); end
            checks++; if (a_out_valid !== 1'b1 || a_data !== data[owner] || a_strb !== strb[owner]) begin errors++; $display("FAIL rr_data beat %0d got %b %h %h exp 1 %h %h", n, a_out_valid, a_data, a_strb, data[owner], strb[owner]); end
            checks++; if (a_ready !== 4'(1 << owner)) begin errors++; $display("FAIL rr_in_ready beat %0d got %b exp %b", n, a_ready, 4'(1 << owner)); end
            checks++; if (a_busy !== (n % 4 != 0)) begin errors++; $display("FAIL rr_busy beat %0d got %b exp %b", n, a_busy, n % 4 != 0); end
            tick();
        end
    endtask

    task automatic test_valid_drop();
        do_reset();
        a_valid = 4'b0100; a_out_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            #1;
            checks++; if (a_grant !== 4'b0100 || a_ready !== 4'b0100 || a_data !== data[2]) begin errors++; $display("FAIL drop_beat%0d got grant %b ready %b data %h exp 0100 0100 %h", n, a_grant, a_ready, a_data, data[2]); end
            tick();
        end
        a_valid = 4'b0000;
        #1;
        checks++; if (a_out_valid !== 1'b0 || a_grant !== 4'b0000 || a_busy !== 1'b1) begin errors++; $display("FAIL drop_bubble got valid %b grant %b busy %b exp 0 0000 1", a_out_valid, a_grant, a_busy); end
        tick();
        a_valid = 4'b1001;
        #1;
        checks++; if (a_grant !== 4'b1000 || a_data !== data[3] || a_busy !== 1'b0) begin errors++; $display("FAIL drop_next_search got grant %b data %h busy %b exp 1000 %h 0", a_grant, a_data, a_busy, data[3]); end
    endtask

    task automatic test_backpressure();
        do_reset();
        a_valid = 4'b0010; a_out_ready = 1'b1;
        tick();
        a_valid = 4'b1111; a_out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            #1;
            checks++; if (a_data !== data[1] || a_strb !== strb[1] || a_out_valid !== 1'b1) begin errors++; $display("FAIL stall_data cyc %0d got %b %h %h exp 1 %h %h", n, a_out_valid, a_data, a_strb, data[1], strb[1]); end
            checks++; if (a_ready !== 4'b0000 || a_grant !== 4'b0010 || a_busy !== 1'b1) begin errors++; $display("FAIL stall_ctrl cyc %0d got ready %b grant %b busy %b exp 0000 0010 1", n, a_ready, a_grant, a_busy); end
            tick();
        end
        a_out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++; if (a_grant !== 4'b0010 || a_ready !== 4'b0010) begin errors++; $display("FAIL stall_resume beat %0d got grant %b ready %b exp 0010 0010", n, a_grant, a_ready); end
            tick();
        end
        #1;
        checks++; if (a_grant !== 4'b0100 || a_busy !== 1'b0) begin errors++; $display("FAIL stall_handover got grant %b busy %b exp 0100 0", a_grant, a_busy); end
    endtask

    task automatic test_burst_one();
        do_reset();
        b_valid = 4'b0011; b_out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            #1;
            checks++; if (b_grant !== 4'(1 << (n % 2)) || b_data !== data[n % 2]) begin errors++; $display("FAIL b1_grant cyc %0d got %b %h exp %b %h", n, b_grant, b_data, 4'(1 << (n % 2)), data[n % 2]); end
            checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL b1_busy cyc %0d got %b exp 0", n, b_busy); end
            tick();
        end
        b_out_ready = 1'b0;
        tick();
        #1;
        checks++; if (b_busy !== 1'b1 || b_ready !== 4'b0000) begin errors++; $display("FAIL b1_stall_lock got busy %b ready %b exp 1 0000", b_busy, b_ready); end
        b_valid = '0;
    endtask

    task automatic test_clear();
        do_reset();
        a_valid = 4'b1000; a_out_ready = 1'b1;
        tick();
        #1;
        checks++; if (a_grant !== 4'b1000 || a_busy !== 1'b1) begin errors++; $display("FAIL clr_locked got grant %b busy %b exp 1000 1", a_grant, a_busy); end
        a_valid = 4'b1001; a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        #1;
        checks++; if (a_grant !== 4'b0001 || a_busy !== 1'b0 || a_data !== data[0]) begin errors++; $display("FAIL clr_restart got grant %b busy %b data %h exp 0001 0 %h", a_grant, a_busy, a_data, data[0]); end
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (a_busy !== 1'b0 || a_grant !== 4'b0001) begin errors++; $display("FAIL async_reset got busy %b grant %b exp 0 0001", a_busy, a_grant); end
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            data[k] = 32'hD000_0000 + 32'(k) * 32'h0101_0101;
            strb[k] = 4'(1 << k);
        end
        test_reset();
        test_round_robin();
        test_valid_drop();
        test_backpressure();
        test_burst_one();
        test_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
